// File: rtl/gsr_pulse_ctrl.sv
// Global set/reset sequencer: arbitrates channel requests, then runs a timed
// SETUP / PULSE / HOLD sequence on gsr_o (and optionally gts_o) before acking.
//   state | meaning
//   IDLE  | waiting for an eligible request
//   SETUP | pre-pulse settle, gts_o asserted when enabled
//   PULSE | gsr_o asserted for the latched length
//   HOLD  | post-pulse settle before acknowledge
//   DONE  | one-cycle ack to the granted channel, count update
module gsr_pulse_ctrl #(
    parameter int NUM_SRC       = 2,
    parameter int CNT_W         = 8,
    parameter int SETUP_CYCLES  = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int USE_GTS       = 0,
    parameter int USE_PRIMITIVE = 1
) (
    input  logic               clk,
    input  logic               plrest_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [CNT_W-1:0]   pulse_len,
    output logic [NUM_SRC-1:0] ack,
    output logic               busy,
    output logic               gsr_o,
    output logic               gts_o,
    output logic [15:0]        pulse_count
);
    localparam int TMR_W = (CNT_W > 8) ? CNT_W : 8;
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);
    localparam logic [TMR_W-1:0]   SETUP_TC = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0]   HOLD_TC  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic               GTS_EN   = (USE_GTS != 0);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_in;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   pick;
    logic [NUM_SRC-1:0] served;
    logic [NUM_SRC-1:0] elig;

    // A channel that has been acked stays locked out until it releases its request.
    assign elig   = req & ~served;
    assign len_in = (pulse_len == '0) ? CNT_W'(1) : pulse_len;

    always_comb begin
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) pick = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge plrest_n) begin
        if (!plrest_n) begin
            state       <= IDLE;
            tmr         <= '0;
            len_q       <= '0;
            grant       <= '0;
            served      <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            gsr_o       <= 1'b0;
            gts_o       <= 1'b0;
            pulse_count <= '0;
        end else begin
            ack    <= '0;
            served <= (served | ((state == DONE) ? ack : '0)) & req;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        grant <= pick;
                        len_q <= len_in;
                        busy  <= 1'b1;
                        gts_o <= GTS_EN;
                        if (SETUP_CYCLES == 0) begin
                            state <= PULSE;
                            tmr   <= TMR_W'(len_in - 1'b1);
                            gsr_o <= 1'b1;
                        end else begin
                            state <= SETUP;
                            tmr   <= SETUP_TC;
                        end
                    end
                end
                SETUP: begin
                    if (tmr == '0) begin
                        state <= PULSE;
                        tmr   <= TMR_W'(len_q - 1'b1);
                        gsr_o <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                PULSE: begin
                    if (tmr == '0) begin
                        state <= HOLD;
                        tmr   <= HOLD_TC;
                        gsr_o <= 1'b0;
                        gts_o <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr == '0) begin
                        state <= DONE;
                        ack   <= ONE_HOT0 << grant;
                        if (pulse_count != 16'hFFFF) pulse_count <= pulse_count + 16'd1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    gsr_o <= 1'b0;
                    gts_o <= 1'b0;
                end
            endcase
        end
    end

    // The device primitive only exists in the vendor flow; the ports carry the same registers.
    generate
        if (USE_PRIMITIVE != 0) begin : g_startup
`ifdef SYNTHESIS
            STARTUPE2 #(
                .PROG_USR("FALSE")
            ) u_startup (
                .CFGCLK    (),
                .CFGMCLK   (),
                .EOS       (),
                .PREQ      (),
                .CLK       (1'b0),
                .GSR       (gsr_o),
                .GTS       (gts_o),
                .KEYCLEARB (1'b1),
                .PACK      (1'b1),
                .USRCCLKO  (1'b0),
                .USRCCLKTS (1'b0),
                .USRDONEO  (1'b1),
                .USRDONETS (1'b1)
            );
`endif
        end
    endgenerate

endmodule

// File: tb/tb_gsr_pulse_ctrl.sv
// Bench for gsr_pulse_ctrl: directed vector table, multi-cycle corner sequences,
// and a randomized run against a position-in-sequence reference model.
module tb_gsr_pulse_ctrl;
    logic        clk = 1'b0;
    logic        plrest_n;
    logic [1:0]  req_a, ack_a, req_b, ack_b;
    logic [7:0]  len_a, len_b;
    logic        busy_a, gsr_a, gts_a, busy_b, gsr_b, gts_b;
    logic [15:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gsr_pulse_ctrl #(.NUM_SRC(2), .CNT_W(8), .SETUP_CYCLES(4), .HOLD_CYCLES(16),
                     .USE_GTS(0), .USE_PRIMITIVE(1)) dut_a (
        .clk(clk), .plrest_n(plrest_n), .req(req_a), .pulse_len(len_a), .ack(ack_a),
        .busy(busy_a), .gsr_o(gsr_a), .gts_o(gts_a), .pulse_count(cnt_a));

    gsr_pulse_ctrl #(.NUM_SRC(2), .CNT_W(8), .SETUP_CYCLES(2), .HOLD_CYCLES(3),
                     .USE_GTS(1), .USE_PRIMITIVE(1)) dut_b (
        .clk(clk), .plrest_n(plrest_n), .req(req_b), .pulse_len(len_b), .ack(ack_b),
        .busy(busy_b), .gsr_o(gsr_b), .gts_o(gts_b), .pulse_count(cnt_b));

    typedef struct {
        logic [1:0] req;
        logic [7:0] len;
        int         gsr;
        logic [1:0] ack;
        int         slen;
    } vec_t;

    typedef struct {
        bit         active;
        int         pos;
        int         len;
        int         g;
        int         cnt;
        logic [1:0] served;
    } mdl_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each sequence is S + len + H + 1 cycles long; everything follows from position.
    function automatic mdl_t step(mdl_t m, logic [1:0] r, logic [7:0] l, int s, int h);
        mdl_t       n = m;
        logic [1:0] elig = r & ~m.served;
        bit         was_done = m.active && (m.pos == s + m.len + h + 1);
        n.served = (m.served | (was_done ? (2'b01 << m.g) : 2'b00)) & r;
        if (was_done) n.active = 1'b0;
        else if (m.active) n.pos = m.pos + 1;
        else if (elig != 2'b00) begin
            n.active = 1'b1;
            n.pos    = 1;
            n.len    = (l == 8'd0) ? 1 : int'(l);
            n.g      = elig[0] ? 0 : 1;
        end
        if (n.active && n.pos == s + n.len + h + 1 && n.cnt < 65535) n.cnt++;
        return n;
    endfunction

    task automatic check_mdl(input string nm, input mdl_t m, input int s, input int h,
                             input bit gts_en, input logic [1:0] ack, input logic busy,
                             input logic gsr, input logic gts, input logic [15:0] cnt);
        int tot;
        tot = s + m.len + h + 1;
        check({nm, ".busy"}, busy, m.active);
        check({nm, ".gsr"},  gsr,  m.active && m.pos > s && m.pos <= s + m.len);
        check({nm, ".gts"},  gts,  gts_en && m.active && m.pos <= s + m.len);
        check({nm, ".ack"},  ack,  (m.active && m.pos == tot) ? (2'b01 << m.g) : 2'b00);
        check({nm, ".cnt"},  cnt,  m.cnt);
    endtask

    task automatic seq_a(input logic [1:0] r, input logic [7:0] l, input int drop_n,
                         input logic [7:0] l2, output int gc, output int gf,
                         output logic [1:0] av, output int sl);
        int n;
        gc = 0; gf = 0; av = 2'b00; sl = 0;
        req_a = r;
        len_a = l;
        tick();
        n = 1;
        while (n <= 400) begin
            if (n == 1) len_a = l2;
            if (n == drop_n) req_a = 2'b00;
            if (gsr_a) begin
                gc++;
                if (gf == 0) gf = n;
            end
            if (ack_a != 2'b00) begin
                av = ack_a;
                sl = n;
                break;
            end
            tick();
            n++;
        end
        req_a = 2'b00;
        tick();
    endtask

    initial begin
        vec_t       vecs[5];
        int         gc, gf, sl, exp_cnt, n, acks;
        logic [1:0] av;
        logic [1:0] ackh[1:60];
        logic       busyh[1:60];
        mdl_t       ma, mb;

        vecs[0] = '{req: 2'b01, len: 8'd3,   gsr: 3,   ack: 2'b01, slen: 24};
        vecs[1] = '{req: 2'b10, len: 8'd0,   gsr: 1,   ack: 2'b10, slen: 22};
        vecs[2] = '{req: 2'b11, len: 8'd1,   gsr: 1,   ack: 2'b01, slen: 22};
        vecs[3] = '{req: 2'b10, len: 8'd7,   gsr: 7,   ack: 2'b10, slen: 28};
        vecs[4] = '{req: 2'b01, len: 8'd255, gsr: 255, ack: 2'b01, slen: 276};

        plrest_n = 1'b0;
        req_a = 2'b00; len_a = 8'd0; req_b = 2'b00; len_b = 8'd0;
        #17;
        check("rst.busy", busy_a, 1'b0);
        check("rst.gsr", gsr_a, 1'b0);
        check("rst.ack", ack_a, 2'b00);
        check("rst.cnt", cnt_a, 16'd0);
        check("rst.gts_b", gts_b, 1'b0);
        tick();
        plrest_n = 1'b1;

        // Reset in the middle of PULSE: outputs drop without a clock edge.
        req_a = 2'b01; len_a = 8'd8;
        tick();
        repeat (5) tick();
        check("arst.gsr_before", gsr_a, 1'b1);
        req_a = 2'b10;
        #2 plrest_n = 1'b0;
        #1;
        check("arst.gsr", gsr_a, 1'b0);
        check("arst.busy", busy_a, 1'b0);
        check("arst.ack", ack_a, 2'b00);
        check("arst.cnt", cnt_a, 16'd0);
        tick();
        check("arst.held", busy_a, 1'b0);
        #1 plrest_n = 1'b1;
        tick();
        check("arst.first_grant", busy_a, 1'b1);
        req_a = 2'b00;
        n = 1;
        while (ack_a == 2'b00 && n < 60) begin
            tick();
            n++;
        end
        check("arst.slen", n, 29);
        check("arst.ack_after", ack_a, 2'b10);
        check("arst.cnt_after", cnt_a, 16'd1);
        tick();
        exp_cnt = 1;

        foreach (vecs[i]) begin
            seq_a(vecs[i].req, vecs[i].len, 1, 8'($urandom), gc, gf, av, sl);
            exp_cnt++;
            check($sformatf("vec%0d.gsr_cycles", i), gc, vecs[i].gsr);
            check($sformatf("vec%0d.gsr_first", i), gf, 5);
            check($sformatf("vec%0d.ack", i), av, vecs[i].ack);
            check($sformatf("vec%0d.slen", i), sl, vecs[i].slen);
            check($sformatf("vec%0d.cnt", i), cnt_a, exp_cnt);
            check($sformatf("vec%0d.idle", i), busy_a, 1'b0);
        end

        // Both channels held: ch0, one IDLE cycle, then ch1, then no repeat.
        req_a = 2'b11; len_a = 8'd0;
        tick();
        gc = 0; acks = 0;
        for (int k = 1; k <= 60; k++) begin
            ackh[k]  = ack_a;
            busyh[k] = busy_a;
            if (gsr_a) gc++;
            if (ack_a != 2'b00) acks++;
            if (k == 45) req_a = 2'b00;
            tick();
        end
        exp_cnt += 2;
        check("both.ack0", ackh[22], 2'b01);
        check("both.gap", busyh[23], 1'b0);
        check("both.regrant", busyh[24], 1'b1);
        check("both.ack1", ackh[45], 2'b10);
        check("both.no_third", busyh[50], 1'b0);
        check("both.gsr_cycles", gc, 2);
        check("both.acks", acks, 2);
        check("both.cnt", cnt_a, exp_cnt);

        // Length changed during SETUP and request dropped during PULSE.
        seq_a(2'b01, 8'd4, 6, 8'd9, gc, gf, av, sl);
        exp_cnt++;
        check("latch.gsr_cycles", gc, 4);
        check("latch.ack", av, 2'b01);
        check("latch.slen", sl, 25);
        check("latch.cnt", cnt_a, exp_cnt);

        // Saturation of the completed-sequence counter.
        force dut_a.pulse_count = 16'hFFFE;
        #1 release dut_a.pulse_count;
        seq_a(2'b01, 8'd0, 1, 8'd0, gc, gf, av, sl);
        check("sat.reach", cnt_a, 16'hFFFF);
        seq_a(2'b10, 8'd2, 1, 8'd2, gc, gf, av, sl);
        check("sat.hold", cnt_a, 16'hFFFF);
        check("sat.ack", av, 2'b10);

        // Tri-state framing with a short setup.
        req_b = 2'b01; len_b = 8'd5;
        tick();
        req_b = 2'b00;
        gc = 0; gf = 0; n = 0; av = 2'b00; sl = 0;
        for (int k = 1; k <= 14; k++) begin
            if (gts_b) n++;
            if (k == 1) check("gts.first", gts_b, 1'b1);
            if (k == 8) check("gts.off", gts_b, 1'b0);
            if (gsr_b) begin
                gc++;
                if (gf == 0) gf = k;
            end
            if (ack_b != 2'b00) begin
                av = ack_b;
                sl = k;
            end
            tick();
        end
        check("gts.cycles", n, 7);
        check("gts.gsr_cycles", gc, 5);
        check("gts.gsr_first", gf, 3);
        check("gts.ack", av, 2'b01);
        check("gts.slen", sl, 11);

        // Randomized run, both instances against the model.
        plrest_n = 1'b0;
        #1;
        plrest_n = 1'b1;
        ma = '{active: 1'b0, pos: 0, len: 1, g: 0, cnt: 0, served: 2'b00};
        mb = ma;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            ma = step(ma, req_a, len_a, 4, 16);
            mb = step(mb, req_b, len_b, 2, 3);
            #1;
            check_mdl("rnd_a", ma, 4, 16, 1'b0, ack_a, busy_a, gsr_a, gts_a, cnt_a);
            check_mdl("rnd_b", mb, 2, 3, 1'b1, ack_b, busy_b, gsr_b, gts_b, cnt_b);
            if ($urandom_range(0, 7) == 0) req_a = 2'($urandom);
            if ($urandom_range(0, 5) == 0) req_b = 2'($urandom);
            len_a = 8'($urandom_range(0, 6));
            len_b = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 299) == 0) begin
                plrest_n = 1'b0;
                ma = '{active: 1'b0, pos: 0, len: 1, g: 0, cnt: 0, served: 2'b00};
                mb = ma;
                #1;
                check_mdl("rnd_rst_a", ma, 4, 16, 1'b0, ack_a, busy_a, gsr_a, gts_a, cnt_a);
                check_mdl("rnd_rst_b", mb, 2, 3, 1'b1, ack_b, busy_b, gsr_b, gts_b, cnt_b);
                #1 plrest_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gsr_pulse_ctrl.md
GSR_PULSE_CTRL -- requirements
Module: gsr_pulse_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2: number of independent reset-request channels (1..8).
REQ-002 Parameter CNT_W, default 8: width of the runtime pulse-length input.
REQ-003 Parameter SETUP_CYCLES, default 4: cycles of pre-pulse setup (0 allowed, 0..255).
REQ-004 Parameter HOLD_CYCLES, default 16: post-pulse settle cycles before acknowledge (1..255).
REQ-005 Parameter USE_GTS, default 0: 1 = assert global tri-state through SETUP and PULSE.
REQ-006 Parameter USE_PRIMITIVE, default 1: 1 = drive gsr_o/gts_o into an internal STARTUPE2 (PROG_USR "FALSE"; CLK/USRCCLKO/USRCCLKTS tied 0; KEYCLEARB/PACK/USRDONEO/USRDONETS tied 1); 0 = no primitive.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 plrest_n  input  1  asynchronous active-low reset.
REQ-009 req  input  NUM_SRC  level request per channel, bit i = channel i.
REQ-010 pulse_len  input  CNT_W  requested GSR pulse length in cycles, sampled at grant.
REQ-011 ack  output  NUM_SRC  one-cycle completion pulse to the granted channel.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 gsr_o  output  1  global set/reset drive (active high).
REQ-014 gts_o  output  1  global tri-state drive (active high).
REQ-015 pulse_count  output  16  number of completed GSR sequences, saturating.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, DONE.
REQ-017 IDLE: if any req bit high at edge t, grant lowest-index set bit, latch grant index and len = max(pulse_len,1), go SETUP at t+1 (PULSE if SETUP_CYCLES=0).
REQ-018 SETUP SHALL last exactly SETUP_CYCLES cycles, then PULSE.
REQ-019 PULSE SHALL last exactly len cycles; gsr_o high in PULSE and only in PULSE; pulse_len=0 yields a 1-cycle pulse.
REQ-020 HOLD SHALL last exactly HOLD_CYCLES cycles, then DONE.
REQ-021 DONE SHALL last one cycle: ack[grant]=1, all other ack bits 0, pulse_count incremented; next state IDLE.
REQ-022 pulse_count SHALL saturate at 65535 and never wrap.
REQ-023 gts_o SHALL be high in SETUP and PULSE when USE_GTS=1, constant 0 when USE_GTS=0.
REQ-024 All outputs SHALL be registered; gsr_o/gts_o glitch-free.
REQ-025 Requests SHALL be ignored outside IDLE; a level still held returns to arbitration in the IDLE cycle after DONE (min one IDLE cycle between sequences).
REQ-026 Deassertion of the granted req mid-sequence SHALL NOT abort or shorten the sequence; ack still issued.
REQ-027 Changes of pulse_len after grant SHALL NOT affect the running sequence.
REQ-028 Simultaneous requests: lowest index first; others served in later sequences, each once per held request-and-ack cycle.
REQ-029 Sequence length SHALL be SETUP_CYCLES + len + HOLD_CYCLES + 1 cycles from first non-IDLE cycle to DONE inclusive.

Reset
REQ-030 plrest_n low SHALL immediately force state IDLE, gsr_o=0, gts_o=0, ack=0, busy=0, pulse_count=0, counters 0, independent of clk.
REQ-031 Reset asserted mid-sequence SHALL abort without ack and without count increment; first arbitration at the first edge after plrest_n deasserts.

Verification
REQ-032 Defaults, req=2'b01, pulse_len=3 -> busy from t+1, gsr_o high cycles t+5..t+7, ack=2'b01 at t+24, pulse_count=1.
REQ-033 req=2'b11 held, pulse_len=0 -> ch0 served (gsr_o 1 cycle, ack=01), one IDLE cycle, then ch1 served (ack=10), pulse_count=2.
REQ-034 USE_GTS=1, SETUP_CYCLES=2, pulse_len=5 -> gts_o high 7 consecutive cycles, gsr_o high last 5 of them.
REQ-035 plrest_n low during PULSE -> gsr_o/busy drop same cycle without clock edge, no ack, pulse_count unchanged.
REQ-036 pulse_len changed 4->9 during SETUP, req dropped during PULSE -> gsr_o still exactly 4 cycles, ack still issued.
REQ-037 pulse_count preloaded via 65535 sequences (or forced) -> further sequence leaves pulse_count=65535.
